// File: rtl/gb_pkg.sv
// gb_pkg: shared types and constants for the Game Boy link-cable serial port.
//  serial_state_t  transfer engine state
//  SC_START/SC_CLKSEL  bit positions inside the SC register
//  ADDR_SB/ADDR_SC     bus addresses decoded by the memory unit
package gb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_XFER = 2'd1,
    EXT_XFER = 2'd2
  } serial_state_t;

  localparam int SC_START  = 7;
  localparam int SC_CLKSEL = 0;

  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  // SC read value: unused bits 6..1 read back as ones.
  function automatic logic [7:0] sc_pack(input logic busy, input logic clk_sel);
    return {busy, 6'b111111, clk_sel};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: STAGES-flop synchroniser for an asynchronous input, plus
// single-cycle rise/fall pulses derived from the synchronised level.
//  clk, rst   system clock, async active-low reset
//  d          asynchronous input pin
//  level      synchronised level
//  rise/fall  one-cycle pulses on a synchronised edge
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle pin level so reset release never fabricates an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/serial_link_port.sv
// serial_link_port: Game Boy link-cable serial port. Holds SB (data) and SC
// (control) and shifts one byte per transfer, MSB first, as master (internal
// sclk) or slave (peer sclk). In the enclosing top, sb/sc feed
// regin.serial_data / regin.serial_control and serial_int is ORed into
// interrupt_st[3].
//  clk, rst            system clock, async active-low reset
//  wdata, sb_we, sc_we CPU write data and one-cycle register write strobes
//  sb, sc              register read values; sc = {busy, 6'b111111, clk_sel}
//  serial_int          one-cycle pulse at transfer completion
//  sclk_in, sin        link clock / data from the peer (asynchronous)
//  sclk_out, sclk_oe   link clock driven in master mode and its enable
//  sout                serial data to the peer, idles 1
import gb_pkg::*;

module serial_link_port #(
  parameter int HALF_PERIOD = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wdata,
  input  logic       sb_we,
  input  logic       sc_we,
  output logic [7:0] sb,
  output logic [7:0] sc,
  output logic       serial_int,
  input  logic       sclk_in,
  output logic       sclk_out,
  output logic       sclk_oe,
  input  logic       sin,
  output logic       sout
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  serial_state_t    state;
  logic             clk_sel;
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;

  logic sclk_rise, sclk_fall, sin_sync;
  logic unused_sclk_level, unused_sin_rise, unused_sin_fall;

  logic       abort, div_wrap, shift_fall, shift_rise;
  logic [7:0] sb_load;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sclk_in),
    .level (unused_sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sin_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sin),
    .level (sin_sync),
    .rise  (unused_sin_rise),
    .fall  (unused_sin_fall)
  );

  always_comb begin
    abort      = sc_we && !wdata[SC_START] && (state != IDLE);
    // A same-cycle SB write must be what the first bit comes from.
    sb_load    = sb_we ? wdata : sb;
    div_wrap   = (div_cnt == DIV_W'(HALF_PERIOD - 1));
    shift_fall = 1'b0;
    shift_rise = 1'b0;
    case (state)
      INT_XFER: begin
        shift_fall = div_wrap && sclk_out;
        shift_rise = div_wrap && !sclk_out;
      end
      EXT_XFER: begin
        shift_fall = sclk_fall;
        shift_rise = sclk_rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sb         <= 8'h00;
      clk_sel    <= 1'b0;
      bit_cnt    <= 4'd0;
      div_cnt    <= '0;
      serial_int <= 1'b0;
      sclk_out   <= 1'b1;
      sout       <= 1'b1;
    end else begin
      serial_int <= 1'b0;
      case (state)
        IDLE: begin
          if (sb_we) sb <= wdata;
          if (sc_we) begin
            clk_sel <= wdata[SC_CLKSEL];
            if (wdata[SC_START]) begin
              state   <= wdata[SC_CLKSEL] ? INT_XFER : EXT_XFER;
              sout    <= sb_load[7];
              bit_cnt <= 4'd0;
              div_cnt <= '0;
            end
          end
        end
        default: begin
          // Busy: SB writes and SC writes with the start bit set are ignored.
          if (abort) begin
            // Abort beats any shift edge in the same cycle; sb keeps the partial byte.
            state    <= IDLE;
            clk_sel  <= wdata[SC_CLKSEL];
            sclk_out <= 1'b1;
            sout     <= 1'b1;
            bit_cnt  <= 4'd0;
            div_cnt  <= '0;
          end else begin
            if (state == INT_XFER) begin
              div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
              if (div_wrap) sclk_out <= ~sclk_out;
            end
            if (shift_fall) sout <= sb[7];
            if (shift_rise) begin
              sb      <= {sb[6:0], sin_sync};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state      <= IDLE;
                serial_int <= 1'b1;
                sout       <= 1'b1;
                sclk_out   <= 1'b1;
                bit_cnt    <= 4'd0;
                div_cnt    <= '0;
              end
            end
          end
        end
      endcase
    end
  end

  assign sc      = sc_pack(state != IDLE, clk_sel);
  assign sclk_oe = (state == INT_XFER);

endmodule
